sb_arbiter: RTL and testbench
=============================

# sb_arbiter

Two-master arbiter and access sequencer for the single data-memory slave on the system bus. It grants one of two load/store masters (m0 = core load/store unit, m1 = secondary master such as a debug or DMA port) by round-robin. It turns each granted request into word-aligned slave cycles, using read-modify-write for sub-word stores. It also does byte-lane extraction and sign or zero extension for loads, and returns a one-cycle acknowledge to the requester.

## Interface
- DATA_W, 32, data width; the slave is one word wide.
- ADDR_W, 32, byte address width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mX_req  in  1  request, X ∈ {0,1}; held high with all mX_* fields stable until mX_ack_o.
- mX_re / mX_we  in  1 / 1  load / store; exactly one must be set.
- mX_un_sign  in  1  load extension: 1 = zero-extend, 0 = sign-extend.
- mX_byte_mask  in  4  size: 4'b0001 byte, 4'b0011 half, 4'b1111 word; any other value is illegal.
- mX_addr  in  ADDR_W  byte address.
- mX_wdata  in  DATA_W  store data, right-justified in bits [7:0], [15:0] or [31:0].
- mX_rdata_o  out  DATA_W  extended load data, valid while mX_ack_o = 1.
- mX_ack_o  out  1  one-cycle completion pulse.
- mX_err_o  out  1  qualifies mX_ack_o: the access was rejected.
- s_rdata  in  DATA_W  slave read word; valid the cycle after the address is presented with s_rw_o = 0.
- s_rw_o  out  1  1 = write the addressed word at this clock edge, 0 = read.
- s_addr_o  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}.
- s_wdata_o  out  DATA_W  full word to write.
- busy_o  out  1  high whenever the FSM is not in IDLE.

## Operation
- Reset values:
  - state = IDLE, last_grant = 1 (so m0 wins the first tie).
  - All ack, err and rdata outputs are 0.
  - s_rw_o = 0, s_addr_o = 0, s_wdata_o = 0, busy_o = 0.
- FSM states: IDLE, RD, LD_DONE, WR, RMW_RD, RMW_WR, ERR.
- Arbitration in IDLE:
  - Eligible master: req = 1 and its ack_o = 0 in that cycle. A master must drop req at the edge after its ack.
  - If one master is eligible, grant it. If both are, grant the one ≠ last_grant.
  - On grant, latch that master's fields into a command register and set last_grant.
- Check on grant: the request is illegal if re == we, byte_mask is illegal, half with addr[0] = 1, or word with addr[1:0] ≠ 0. An illegal request goes to ERR.
- Load: IDLE → RD → LD_DONE → IDLE.
  - RD: drive s_addr_o with s_rw_o = 0.
  - LD_DONE: select lane addr[1:0] from s_rdata, shift it to bit 0, extend per un_sign, register it into rdata_o and set ack.
- Word store: IDLE → WR → IDLE. WR drives s_rw_o = 1 and s_wdata_o = wdata, and sets ack.
- Sub-word store: IDLE → RMW_RD → RMW_WR → IDLE.
  - RMW_RD reads the word.
  - RMW_WR writes s_rdata with lane(s) addr[1:0] replaced by wdata[7:0] or [15:0], and sets ack.
- ERR: sets ack and err for one cycle; no slave write, rdata_o = 0.
- s_rw_o is 1 only in WR and RMW_WR. In every other state it is 0, and s_addr_o keeps its last value.
- The ungranted master's ack, err and rdata outputs stay 0.

## Timing
- Request first seen in IDLE in cycle N (grant edge at the end of N).
- Load: slave address in N+1, s_rdata valid in N+2, ack and rdata in N+3.
- Word store: write in N+1, ack in N+2.
- Sub-word store: read in N+1, merged write in N+2, ack in N+3.
- Error: ack and err in N+2.
- ack is registered and lasts exactly one cycle. The FSM is back in IDLE in the ack cycle but masks the acked master. A pending other master can therefore be granted in that same cycle, so there are no dead cycles between back-to-back requesters.
- Simultaneous requests alternate strictly: 0, 1, 0, 1, …
- Reset asserted mid-operation clears all outputs asynchronously, s_rw_o included. A write in progress is abandoned with no partial write and no ack.

## Test plan
- Load, single master:
  - Stimulus: memory word 0x100 = 0x80FF7F01; m0 loads byte, signed, at 0x102.
  - Required: m0_rdata_o = 0xFFFFFFFF in N+3.
  - Repeat with un_sign = 1: 0x000000FF.
- Sub-word store (RMW):
  - Stimulus: memory word 0x200 = 0x11223344; m1 stores half 0xABCD at 0x202.
  - Required: RMW read in N+1, s_wdata_o = 0xABCD3344 with s_rw_o = 1 in N+2, m1_ack_o in N+3.
  - Check: a readback word at 0x200 = 0xABCD3344.
- Contention:
  - Stimulus: m0 and m1 each issue 4 word stores continuously, both requesting from the same cycle.
  - Required: grant order m0, m1, m0, m1, …; each ack exactly one cycle; no gap cycles between accesses.
- Errors:
  - Stimulus: a word load at 0x103; a request with re = we = 1; byte_mask 4'b0101.
  - Required: each gives ack + err in N+2, s_rw_o stays 0, rdata_o = 0.
- Reset mid-store:
  - Stimulus: drive rst low in RMW_RD of a byte store.
  - Required: all outputs are 0 immediately, memory is unchanged, and after release m0 wins the first tie.

Source files
------------

// File: rtl/sb_arbiter.sv
`default_nettype none
// sb_arbiter: round-robin arbiter for two load/store masters sharing one word-wide data-memory slave.
// Sub-word stores become read-modify-write; loads are lane-extracted and sign/zero extended.
module sb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_re,
    input  logic              m0_we,
    input  logic              m0_un_sign,
    input  logic [3:0]        m0_byte_mask,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_req,
    input  logic              m1_re,
    input  logic              m1_we,
    input  logic              m1_un_sign,
    input  logic [3:0]        m1_byte_mask,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              s_rw_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic              busy_o
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        LD_DONE = 3'd2,
        WR      = 3'd3,
        RMW_RD  = 3'd4,
        RMW_WR  = 3'd5,
        ERR     = 3'd6
    } state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              cmd_sel_q, cmd_sel_d;
    logic              cmd_un_sign_q, cmd_un_sign_d;
    logic [3:0]        cmd_mask_q, cmd_mask_d;
    logic [1:0]        cmd_off_q, cmd_off_d;
    logic [15:0]       cmd_wdata_q, cmd_wdata_d;
    logic              s_rw_q, s_rw_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
    logic              m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
    logic              m0_err_q, m0_err_d, m1_err_q, m1_err_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

    logic              elig0, elig1, pick1, g_legal;
    logic              g_re, g_we, g_un_sign;
    logic [3:0]        g_mask;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [4:0]        lane_sh;
    logic [DATA_W-1:0] lane_word, load_val, merged;

    always_comb begin
        // A master is masked in its own ack cycle so its stale req is not re-granted.
        elig0     = m0_req & ~m0_ack_q;
        elig1     = m1_req & ~m1_ack_q;
        pick1     = elig1 & (~elig0 | ~last_grant_q);
        g_re      = pick1 ? m1_re        : m0_re;
        g_we      = pick1 ? m1_we        : m0_we;
        g_un_sign = pick1 ? m1_un_sign   : m0_un_sign;
        g_mask    = pick1 ? m1_byte_mask : m0_byte_mask;
        g_addr    = pick1 ? m1_addr      : m0_addr;
        g_wdata   = pick1 ? m1_wdata     : m0_wdata;
        case (g_mask)
            MASK_B:  g_legal = 1'b1;
            MASK_H:  g_legal = ~g_addr[0];
            MASK_W:  g_legal = (g_addr[1:0] == 2'b00);
            default: g_legal = 1'b0;
        endcase
        g_legal = g_legal & (g_re ^ g_we);
    end

    always_comb begin
        lane_sh   = {cmd_off_q, 3'b000};
        lane_word = s_rdata >> lane_sh;
        case (cmd_mask_q)
            MASK_B:  load_val = {{(DATA_W-8){~cmd_un_sign_q & lane_word[7]}}, lane_word[7:0]};
            MASK_H:  load_val = {{(DATA_W-16){~cmd_un_sign_q & lane_word[15]}}, lane_word[15:0]};
            default: load_val = lane_word;
        endcase
        merged = s_rdata;
        if (cmd_mask_q == MASK_B) merged[lane_sh +: 8]  = cmd_wdata_q[7:0];
        else                      merged[lane_sh +: 16] = cmd_wdata_q;
    end

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cmd_sel_d     = cmd_sel_q;
        cmd_un_sign_d = cmd_un_sign_q;
        cmd_mask_d    = cmd_mask_q;
        cmd_off_d     = cmd_off_q;
        cmd_wdata_d   = cmd_wdata_q;
        s_addr_d      = s_addr_q;
        s_wdata_d     = s_wdata_q;
        s_rw_d        = 1'b0;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;
        m0_err_d      = 1'b0;
        m1_err_d      = 1'b0;
        m0_rdata_d    = '0;
        m1_rdata_d    = '0;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    last_grant_d  = pick1;
                    cmd_sel_d     = pick1;
                    cmd_un_sign_d = g_un_sign;
                    cmd_mask_d    = g_mask;
                    cmd_off_d     = g_addr[1:0];
                    cmd_wdata_d   = g_wdata[15:0];
                    if (!g_legal) begin
                        state_d = ERR;
                    end else begin
                        s_addr_d = {g_addr[ADDR_W-1:2], 2'b00};
                        if (g_re) begin
                            state_d = RD;
                        end else if (g_mask == MASK_W) begin
                            state_d   = WR;
                            s_rw_d    = 1'b1;
                            s_wdata_d = g_wdata;
                        end else begin
                            state_d = RMW_RD;
                        end
                    end
                end
            end
            RD:     state_d = LD_DONE;
            RMW_RD: begin
                state_d = RMW_WR;
                s_rw_d  = 1'b1;
            end
            LD_DONE, WR, RMW_WR, ERR: begin
                state_d  = IDLE;
                m0_ack_d = ~cmd_sel_q;
                m1_ack_d = cmd_sel_q;
                m0_err_d = ~cmd_sel_q & (state_q == ERR);
                m1_err_d = cmd_sel_q & (state_q == ERR);
                if (state_q == LD_DONE) begin
                    if (cmd_sel_q) m1_rdata_d = load_val;
                    else           m0_rdata_d = load_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cmd_sel_q     <= 1'b0;
            cmd_un_sign_q <= 1'b0;
            cmd_mask_q    <= 4'b0000;
            cmd_off_q     <= 2'b00;
            cmd_wdata_q   <= '0;
            s_rw_q        <= 1'b0;
            s_addr_q      <= '0;
            s_wdata_q     <= '0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
            m0_err_q      <= 1'b0;
            m1_err_q      <= 1'b0;
            m0_rdata_q    <= '0;
            m1_rdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cmd_sel_q     <= cmd_sel_d;
            cmd_un_sign_q <= cmd_un_sign_d;
            cmd_mask_q    <= cmd_mask_d;
            cmd_off_q     <= cmd_off_d;
            cmd_wdata_q   <= cmd_wdata_d;
            s_rw_q        <= s_rw_d;
            s_addr_q      <= s_addr_d;
            s_wdata_q     <= s_wdata_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
            m0_err_q      <= m0_err_d;
            m1_err_q      <= m1_err_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
        end
    end

    // The merged word depends on the slave data returned in the RMW_WR cycle itself.
    assign s_wdata_o  = (state_q == RMW_WR) ? merged : s_wdata_q;
    assign s_rw_o     = s_rw_q;
    assign s_addr_o   = s_addr_q;
    assign busy_o     = (state_q != IDLE);
    assign m0_ack_o   = m0_ack_q;
    assign m1_ack_o   = m1_ack_q;
    assign m0_err_o   = m0_err_q;
    assign m1_err_o   = m1_err_q;
    assign m0_rdata_o = m0_rdata_q;
    assign m1_rdata_o = m1_rdata_q;
endmodule
`default_nettype wire

// File: tb/tb_sb_arbiter.sv
`default_nettype none
// tb_sb_arbiter: directed stimulus, a word-memory slave and a cycle-schedule reference model.
module tb_sb_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req [2];
    logic        re  [2];
    logic        we  [2];
    logic        us  [2];
    logic [3:0]  bm  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    wire  [1:0]  ack, err;
    wire  [31:0] rd0, rd1;
    logic [31:0] s_rdata = 32'h0;
    wire         s_rw, busy;
    wire  [31:0] s_addr, s_wdata;

    sb_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(req[0]), .m0_re(re[0]), .m0_we(we[0]), .m0_un_sign(us[0]),
        .m0_byte_mask(bm[0]), .m0_addr(ad[0]), .m0_wdata(wd[0]),
        .m0_rdata_o(rd0), .m0_ack_o(ack[0]), .m0_err_o(err[0]),
        .m1_req(req[1]), .m1_re(re[1]), .m1_we(we[1]), .m1_un_sign(us[1]),
        .m1_byte_mask(bm[1]), .m1_addr(ad[1]), .m1_wdata(wd[1]),
        .m1_rdata_o(rd1), .m1_ack_o(ack[1]), .m1_err_o(err[1]),
        .s_rdata(s_rdata), .s_rw_o(s_rw), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .busy_o(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Slave memory and the model's own copy of it
    logic [31:0] smem [logic [31:0]];
    logic [31:0] mm   [logic [31:0]];
    function automatic logic [31:0] srd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : 32'h0;
    endfunction
    function automatic logic [31:0] mrd(input logic [31:0] a);
        return mm.exists(a) ? mm[a] : 32'h0;
    endfunction
    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        smem[a] = v;
        mm[a]   = v;
    endtask

    always @(posedge clk) begin
        if (s_rw) smem[s_addr] = s_wdata;
        else      s_rdata <= srd(s_addr);
    end

    // Model: per-cycle expectations in a ring indexed by absolute cycle number
    bit          r_busy [16];
    bit   [1:0]  r_ack  [16];
    bit   [1:0]  r_err  [16];
    logic [31:0] r_rd   [16];
    bit          r_av   [16];
    logic [31:0] r_addr [16];
    bit          r_rw   [16];
    logic [31:0] r_wd   [16];
    int          cyc = 0;
    int          free_cyc = 0;
    bit          last = 1'b1;
    logic [31:0] cur_addr = 32'h0;

    task automatic clr(input int k);
        r_busy[k] = 0; r_ack[k] = 0; r_err[k] = 0; r_rd[k] = 0;
        r_av[k] = 0; r_addr[k] = 0; r_rw[k] = 0; r_wd[k] = 0;
    endtask

    task automatic sched(input int m, input int n);
        logic [31:0] a, szm, v;
        int off, size, k1, k2, k3;
        bit ok;
        a    = {ad[m][31:2], 2'b00};
        off  = int'(ad[m][1:0]);
        size = (bm[m] == 4'b0001) ? 1 : (bm[m] == 4'b0011) ? 2 : (bm[m] == 4'b1111) ? 4 : 0;
        ok   = (re[m] != we[m]) && (size != 0) && ((size == 0) || (off % size == 0));
        szm  = (size >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        k1 = (n + 1) % 16; k2 = (n + 2) % 16; k3 = (n + 3) % 16;
        r_busy[k1] = 1;
        if (!ok) begin
            r_ack[k2][m] = 1; r_err[k2][m] = 1; r_rd[k2] = 0;
            free_cyc = n + 2;
        end else if (re[m]) begin
            v = (mrd(a) >> (8 * off)) & szm;
            if (!us[m] && size < 4 && v[8 * size - 1]) v = v | ~szm;
            r_av[k1] = 1; r_addr[k1] = a; r_busy[k2] = 1;
            r_ack[k3][m] = 1; r_rd[k3] = v;
            free_cyc = n + 3;
        end else if (size == 4) begin
            r_av[k1] = 1; r_addr[k1] = a; r_rw[k1] = 1; r_wd[k1] = wd[m];
            r_ack[k2][m] = 1;
            free_cyc = n + 2;
        end else begin
            r_av[k1] = 1; r_addr[k1] = a; r_busy[k2] = 1; r_rw[k2] = 1;
            r_wd[k2] = (mrd(a) & ~(szm << (8 * off))) | ((wd[m] & szm) << (8 * off));
            r_ack[k3][m] = 1;
            free_cyc = n + 3;
        end
    endtask

    always @(negedge clk) begin
        int k, pick;
        bit [1:0] ea;
        bit el0, el1;
        k = cyc % 16;
        if (!rst) begin
            chk("rst ack", {30'd0, ack}, 32'h0);
            chk("rst err", {30'd0, err}, 32'h0);
            chk("rst rdata0", rd0, 32'h0);
            chk("rst rdata1", rd1, 32'h0);
            chk("rst s_rw", {31'd0, s_rw}, 32'h0);
            chk("rst s_addr", s_addr, 32'h0);
            chk("rst s_wdata", s_wdata, 32'h0);
            chk("rst busy", {31'd0, busy}, 32'h0);
            for (int i = 0; i < 16; i++) clr(i);
            free_cyc = 0;
            last     = 1'b1;
            cur_addr = 32'h0;
        end else begin
            if (r_av[k]) cur_addr = r_addr[k];
            chk("ack0", {31'd0, ack[0]}, {31'd0, r_ack[k][0]});
            chk("ack1", {31'd0, ack[1]}, {31'd0, r_ack[k][1]});
            chk("err0", {31'd0, err[0]}, {31'd0, r_err[k][0]});
            chk("err1", {31'd0, err[1]}, {31'd0, r_err[k][1]});
            chk("rdata0", rd0, r_ack[k][0] ? r_rd[k] : 32'h0);
            chk("rdata1", rd1, r_ack[k][1] ? r_rd[k] : 32'h0);
            chk("s_rw", {31'd0, s_rw}, {31'd0, r_rw[k]});
            chk("s_addr", s_addr, cur_addr);
            chk("busy", {31'd0, busy}, {31'd0, r_busy[k]});
            if (r_rw[k]) begin
                chk("s_wdata", s_wdata, r_wd[k]);
                mm[cur_addr] = r_wd[k];
            end
            ea = r_ack[k];
            clr(k);
            if (cyc >= free_cyc) begin
                el0 = req[0] && !ea[0];
                el1 = req[1] && !ea[1];
                if (el0 || el1) begin
                    pick = (el0 && el1) ? (last ? 0 : 1) : (el1 ? 1 : 0);
                    last = (pick == 1);
                    sched(pick, cyc);
                end
            end
        end
        cyc++;
    end

    // Ack order log for arbitration checks
    bit      logging = 0;
    int      q_m[$];
    longint  q_t[$];
    always @(negedge clk) begin
        if (logging && rst) begin
            if (ack[0]) begin q_m.push_back(0); q_t.push_back($time); end
            if (ack[1]) begin q_m.push_back(1); q_t.push_back($time); end
        end
    end

    task automatic issue(input int m, input bit r, input bit w, input bit u, input logic [3:0] mask,
                         input logic [31:0] a, input logic [31:0] d, output int lat,
                         output logic [31:0] rdv, output bit ev, output int wr_n, output logic [31:0] wr_d);
        int n;
        n = 0; lat = -1; wr_n = -1; wr_d = 0; rdv = 0; ev = 0;
        @(posedge clk); #1;
        re[m] = r; we[m] = w; us[m] = u; bm[m] = mask; ad[m] = a; wd[m] = d; req[m] = 1;
        while (lat < 0 && n < 40) begin
            @(negedge clk);
            if (s_rw && wr_n < 0) begin wr_n = n; wr_d = s_wdata; end
            if (ack[m]) begin lat = n; rdv = (m != 0) ? rd1 : rd0; ev = err[m]; end
            n++;
        end
        if (lat < 0) begin
            n_chk++; n_fail++;
            $display("FAIL timeout m%0d: no ack after %0d cycles, expected one", m, n);
        end
        @(posedge clk); #1;
        req[m] = 0;
    endtask

    task automatic solo(input string nm, input int m, input bit r, input bit w, input bit u,
                        input logic [3:0] mask, input logic [31:0] a, input logic [31:0] d,
                        input int e_lat, input logic [31:0] e_rd, input bit e_err,
                        input int e_wn, input logic [31:0] e_wd);
        int lat, wn;
        logic [31:0] rdv, wdv;
        bit ev;
        issue(m, r, w, u, mask, a, d, lat, rdv, ev, wn, wdv);
        chk({nm, " latency"}, lat, e_lat);
        chk({nm, " rdata"}, rdv, e_rd);
        chk({nm, " err"}, {31'd0, ev}, {31'd0, e_err});
        chk({nm, " write cycle"}, wn, e_wn);
        if (e_wn >= 0) chk({nm, " write data"}, wdv, e_wd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 0; re[i] = 0; we[i] = 0; us[i] = 0; bm[i] = 4'b0; ad[i] = 0; wd[i] = 0;
        end
        preload(32'h100, 32'h80FF_7F01);
        preload(32'h200, 32'h1122_3344);
        preload(32'h300, 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        #1 rst = 1;

        solo("ld byte signed",   0, 1, 0, 0, 4'b0001, 32'h102, 0, 3, 32'hFFFF_FFFF, 0, -1, 0);
        solo("ld byte unsigned", 0, 1, 0, 1, 4'b0001, 32'h102, 0, 3, 32'h0000_00FF, 0, -1, 0);
        solo("ld half signed",   0, 1, 0, 0, 4'b0011, 32'h102, 0, 3, 32'hFFFF_80FF, 0, -1, 0);
        solo("ld byte m1",       1, 1, 0, 0, 4'b0001, 32'h101, 0, 3, 32'h0000_007F, 0, -1, 0);
        solo("rmw half m1",      1, 0, 1, 0, 4'b0011, 32'h202, 32'hABCD, 3, 0, 0, 2, 32'hABCD_3344);
        solo("readback",         0, 1, 0, 0, 4'b1111, 32'h200, 0, 3, 32'hABCD_3344, 0, -1, 0);
        solo("st word",          0, 0, 1, 0, 4'b1111, 32'h180, 32'h1234_5678, 2, 0, 0, 1, 32'h1234_5678);
        solo("rmw byte m1",      1, 0, 1, 0, 4'b0001, 32'h183, 32'h9A, 3, 0, 0, 2, 32'h9A34_5678);
        solo("err misaligned",   0, 1, 0, 0, 4'b1111, 32'h103, 0, 2, 0, 1, -1, 0);
        solo("err re=we",        0, 1, 1, 0, 4'b1111, 32'h100, 0, 2, 0, 1, -1, 0);
        solo("err mask",         1, 1, 0, 0, 4'b0101, 32'h100, 0, 2, 0, 1, -1, 0);

        // Contention: both masters stream word stores from the same cycle
        q_m.delete(); q_t.delete(); logging = 1;
        fork
            begin
                int l, wn; logic [31:0] x, y; bit e;
                for (int i = 0; i < 4; i++)
                    issue(0, 0, 1, 0, 4'b1111, 32'h400 + 8 * i, 32'hA000_0000 + i, l, x, e, wn, y);
            end
            begin
                int l, wn; logic [31:0] x, y; bit e;
                for (int j = 0; j < 4; j++)
                    issue(1, 0, 1, 0, 4'b1111, 32'h404 + 8 * j, 32'hB000_0000 + j, l, x, e, wn, y);
            end
        join
        logging = 0;
        chk("contention ack count", q_m.size(), 8);
        for (int i = 0; i < q_m.size(); i++) chk("contention grant order", q_m[i], i % 2);
        for (int i = 1; i < q_t.size(); i++) chk("contention ack spacing", 32'(q_t[i] - q_t[i-1]), 20);
        chk("contention mem m1 last", srd(32'h41C), 32'hB000_0003);

        // Reset in RMW_RD of an m0 byte store, leaving last grant on m0
        @(posedge clk); #1;
        re[0] = 0; we[0] = 1; us[0] = 0; bm[0] = 4'b0001; ad[0] = 32'h301; wd[0] = 32'h55; req[0] = 1;
        @(posedge clk); #1;
        chk("pre-reset busy", {31'd0, busy}, 32'h1);
        rst = 0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'h0);
        chk("async rst s_rw", {31'd0, s_rw}, 32'h0);
        chk("async rst s_addr", s_addr, 32'h0);
        chk("async rst ack/err", {28'd0, ack, err}, 32'h0);
        req[0] = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        chk("mem after reset", srd(32'h300), 32'hCAFE_F00D);

        q_m.delete(); q_t.delete(); logging = 1;
        fork
            begin
                int l, wn; logic [31:0] x, y; bit e;
                issue(0, 1, 0, 0, 4'b1111, 32'h100, 0, l, x, e, wn, y);
            end
            begin
                int l, wn; logic [31:0] x, y; bit e;
                issue(1, 1, 0, 0, 4'b1111, 32'h200, 0, l, x, e, wn, y);
            end
        join
        logging = 0;
        chk("post-reset ack count", q_m.size(), 2);
        if (q_m.size() > 0) chk("post-reset first grant", q_m[0], 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
